fxp_add_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one saturating fixed-point adder among NREQ requesters.

---
 rtl/fxp_add_rr_sched.sv | 128 ++++++++++++
 tb/tb_fxp_add_rr_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fxp_add_rr_sched.sv
// Round-robin arbiter feeding one shared saturating Q(INT_W.FRAC_W) adder.
// Two register stages: operand capture (_p1), then sum/saturate (_p2) driving the response port.
module fxp_add_rr_sched #(
    parameter  int NREQ   = 4,
    parameter  int INT_W  = 4,
    parameter  int FRAC_W = 5,
    localparam int W      = INT_W + FRAC_W,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_ovf,
    output logic              rsp_unf
);

    function automatic logic [W+1:0] sat_add(input logic signed [W-1:0] x,
                                             input logic signed [W-1:0] y);
        logic signed [W:0] full;
        full = {x[W-1], x} + {y[W-1], y};
        // Top two bits of the W+1-bit sum disagree exactly when the result left the W-bit range.
        if (full[W:W-1] == 2'b01)
            return {1'b1, 1'b0, 1'b0, {(W-1){1'b1}}};
        else if (full[W:W-1] == 2'b10)
            return {1'b0, 1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {2'b00, full[W-1:0]};
    endfunction

    logic [IDW-1:0]        ptr;
    logic                  vld_p1;
    logic signed [W-1:0]   a_p1;
    logic signed [W-1:0]   b_p1;
    logic [IDW-1:0]        id_p1;
    logic                  vld_p2;
    logic signed [W-1:0]   sum_p2;
    logic [IDW-1:0]        id_p2;
    logic                  ovf_p2;
    logic                  unf_p2;

    logic                  adv1, adv2;
    logic                  grant_any, grant_fire;
    logic [IDW-1:0]        grant_id, cand, ptr_nxt;
    logic signed [W-1:0]   a_sel, b_sel;
    logic [W+1:0]          sat_p1;

    assign adv2 = !vld_p2 || rsp_ready;
    assign adv1 = !vld_p1 || adv2;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign grant_fire = rst && adv1 && grant_any;
    assign ptr_nxt    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
                req_ready[i] = grant_fire;
            end
        end
    end

    assign sat_p1 = sat_add(a_p1, b_p1);

    // Stage 1: operand/ID capture on a grant handshake
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            a_p1  <= a_sel;
            b_p1  <= b_sel;
            id_p1 <= grant_id;
        end
    end

    // Stage 2: saturated sum into the response registers; control and response cleared on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
            id_p2  <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
        end else begin
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    {ovf_p2, unf_p2, sum_p2} <= sat_p1;
                    id_p2                    <= id_p1;
                end
            end
            if (adv1)
                vld_p1 <= grant_any;
            if (grant_fire)
                ptr <= ptr_nxt;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_sum   = sum_p2;
    assign rsp_id    = id_p2;
    assign rsp_ovf   = ovf_p2;
    assign rsp_unf   = unf_p2;

endmodule

// File: tb/tb_fxp_add_rr_sched.sv
// Directed bench for fxp_add_rr_sched: saturation cases, round-robin order, backpressure, reset.
module tb_fxp_add_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 9;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_ovf;
    logic              rsp_unf;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    fxp_add_rr_sched #(.NREQ(NREQ), .INT_W(4), .FRAC_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input int id, input int sum, input int ovf, input int unf);
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},  32'(rsp_id),    32'(id));
        chk({tag, "_sum"}, 32'(rsp_sum),   32'(sum));
        chk({tag, "_ovf"}, 32'(rsp_ovf),   32'(ovf));
        chk({tag, "_unf"}, 32'(rsp_unf),   32'(unf));
    endtask

    // One isolated transaction: offered, handshaken, result two edges after being offered.
    task automatic single(input string tag, input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int sum, input int ovf, input int unf);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid         = 4'(1 << idx);
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        #1;
        chk({tag, "_lat"}, 32'(rsp_valid), 32'd0);
        step();
        chk_rsp(tag, idx, sum, ovf, unf);
        step();
        chk({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id",  32'(rsp_id),    32'd0);
        chk("rst_sum", 32'(rsp_sum),   32'd0);
        chk("rst_ovf", 32'(rsp_ovf),   32'd0);
        chk("rst_unf", 32'(rsp_unf),   32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("idle_rdy", 32'(req_ready), 32'd0);

        // T1..T3: exact, positive saturation, negative saturation; ptr walks 0 -> 1 -> 2
        single("t1", 0, 9'h030, 9'h048, 'h078, 0, 0);
        single("t2", 1, 9'h0E0, 9'h040, 'h0FF, 1, 0);
        single("t3", 3, 9'h100, 9'h1F0, 'h100, 0, 1);

        // T4: all requesters valid, a_i = i*2.0, b = 3/32; ptr is 0 after granting 3
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 9'(i * 'h40);
            req_b[i*W +: W] = 9'h003;
        end
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                req_valid = '0;
                #1;
            end
            if (k < 6) chk($sformatf("t4_rdy%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            else       chk($sformatf("t4_rdy%0d", k), 32'(req_ready), 32'd0);
            if (k >= 2) chk_rsp($sformatf("t4_r%0d", k - 2), (k - 2) % 4, ((k - 2) % 4) * 'h40 + 3, 0, 0);
            step();
        end
        chk("t4_end", 32'(rsp_valid), 32'd0);

        // T5: ptr is 2; stall the response port while all requesters stay valid
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("t5_rdy0", 32'(req_ready), 32'h4);
        step();
        chk("t5_rdy1", 32'(req_ready), 32'h8);
        chk("t5_vld1", 32'(rsp_valid), 32'd0);
        step();
        for (int k = 2; k < 5; k++) begin
            chk_rsp($sformatf("t5_hold%0d", k), 2, 'h83, 0, 0);
            chk($sformatf("t5_rdy%0d", k), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        chk_rsp("t5_rel2", 2, 'h83, 0, 0);
        chk("t5_rdy5", 32'(req_ready), 32'd0);
        step();
        chk_rsp("t5_rel3", 3, 'hC3, 0, 0);
        step();
        chk("t5_end", 32'(rsp_valid), 32'd0);

        // T6: ptr is 0; fill both stages, then reset; ptr would be 2 if not cleared
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step();
        step();
        chk("t6_full", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_rdy", 32'(req_ready), 32'd0);
        step();
        chk("t6_vld", 32'(rsp_valid), 32'd0);
        chk("t6_sum", 32'(rsp_sum),   32'd0);
        chk("t6_id",  32'(rsp_id),    32'd0);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("t6_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        #1;
        chk("t6_lat", 32'(rsp_valid), 32'd0);
        step();
        chk_rsp("t6_first", 1, 'h43, 0, 0);
        step();
        chk("t6_nodup", 32'(rsp_valid), 32'd0);
        step();
        chk("t6_quiet", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
